neuron_stat_updater: RTL and testbench
======================================

Name: neuron_stat_updater

Overview:
- Initiator/sequencer for the status memory's neuron-parameter ports: read port A (1-cycle registered read latency) and write port B.
- On each time-step tick, walks all neurons in order. Per neuron: reads Bias, MembPot, Th and PostSpikeHist; integrates MembPot += Bias with saturation; compares against Th; writes back MembPot and PostSpikeHist.
- Emits one spike event per firing neuron toward the router/packetiser.
- Sits between the time-step controller and the status memory, inside each neuron core.

Parameters:
- NUM_NURNS, 256, neurons swept per time step (must equal 2**NURN_CNT_BIT_WIDTH or less).
- DSIZE, 16, data width of Bias/MembPot/Th; signed two's complement.
- NURN_CNT_BIT_WIDTH, 8, neuron index width.
- STDP_WIN_BIT_WIDTH, 8, PostSpikeHist width (unsigned).

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  time-step tick; sampled only in IDLE.
- busy_o  out  1  high from the cycle after an accepted start_i until done_o.
- done_o  out  1  one-cycle pulse when the sweep completes.
- Addr_StatRd_A_o  out  NURN_CNT_BIT_WIDTH+2  {nurnId, sel}; sel 00 Bias, 01 MembPot, 10 Th, 11 PostSpikeHist.
- rdEn_StatRd_A_o  out  1  read enable, port A.
- data_StatRd_A_i  in  DSIZE  registered read data, valid the cycle after rdEn.
- Addr_StatWr_B_o  out  NURN_CNT_BIT_WIDTH+2  write address, same encoding as port A.
- wrEn_StatWr_B_o  out  1  write enable, port B.
- data_StatWr_B_o  out  DSIZE  write data; hist is zero-extended.
- spike_o  out  1  one-cycle spike pulse.
- spikeNurnId_o  out  NURN_CNT_BIT_WIDTH  id of the firing neuron; valid with spike_o.

Behaviour:
- Reset: FSM goes to IDLE, neuron counter = 0. All outputs are 0 and all captured operand registers are cleared.
- FSM states and per-cycle actions:
  - IDLE: start_i=1 → RB.
  - RB: rdEn, addr {n,00}.
  - RP: rdEn, addr {n,01}; capture bias from data_i.
  - RT: rdEn, addr {n,10}; capture pot.
  - RH: rdEn, addr {n,11}; capture th.
  - CMP: capture hist[STDP_WIN_BIT_WIDTH-1:0]; register sum and fire flag.
  - WP: wrEn, addr {n,01}; spike_o/spikeNurnId_o asserted here if fire.
  - WH: wrEn, addr {n,11}; if n==NUM_NURNS-1 → DONE, else n+1 → RB.
  - DONE: done_o=1, busy_o=0, n=0 → IDLE.
- Timing:
  - Exactly 7 cycles per neuron.
  - start_i accepted in cycle 0 → done_o in cycle 7*NUM_NURNS+1.
- Arithmetic:
  - sum = pot + bias, computed at DSIZE+1 bits and saturated to signed DSIZE: max 0x7FFF, min 0x8000 for DSIZE=16.
  - fire = (sum >= th), signed compare.
- Write-back:
  - fire: MembPot ← 0, PostSpikeHist ← 0.
  - no fire: MembPot ← sum; PostSpikeHist ← hist+1, saturating at 2**STDP_WIN_BIT_WIDTH-1.
- Enable exclusivity: rdEn and wrEn are never high in the same cycle. rdEn is high only in RB..RH; wrEn is high only in WP/WH.
- start_i while busy or in DONE: ignored, not queued.
- Reset mid-sweep: aborts immediately to IDLE. Already-written neurons keep their new values and are not rolled back. No done_o is pulsed.
- Address and data outputs are registered and driven to 0 when their enable is low.

Decomposition:
- Shared package:
  - sel encodings SEL_BIAS=2'b00, SEL_POT=2'b01, SEL_TH=2'b10, SEL_HIST=2'b11 (shared with the status memory);
  - FSM state constants;
  - the signed saturation-limit function.
- One natural sub-module, nurn_integrate_cmp: combinational saturating add, signed compare, and hist increment/clear. Outputs sum, fire, next_hist. The FSM stays in the top module.

Test Plan:
- Single neuron fires (NUM_NURNS=4): n0 bias=0x0010, pot=0x0070, th=0x0080 → spike_o with id 0 in WP; writes {0,01}←0x0000 and {0,11}←0x0000.
- No fire with hist increment: n1 bias=0x0005, pot=0x0010, th=0x0100, hist=0x07 → writes pot=0x0015, hist=0x08; no spike.
- Saturation and hist ceiling:
  - pot=0x7FF0, bias=0x0020, th=0x7FFF → sum saturates to 0x7FFF and fires.
  - pot=0x8005, bias=0xFFF0 → writes 0x8000, no fire.
  - hist=0xFF without fire → stays 0xFF.
- Timing/handshake (NUM_NURNS=4): start_i at cycle 0 → done_o single pulse at cycle 29, busy_o high cycles 1-28. A second start_i at cycle 10 is ignored. Checker confirms rdEn/wrEn never overlap and the address sequence {n,00},{n,01},{n,10},{n,11},{n,01},{n,11}.
- Reset mid-sweep: assert rst_n_i=0 at cycle 12 → all outputs 0 asynchronously, no done_o. Neuron 0 already updated, neuron 1 untouched. A fresh start_i restarts from neuron 0.

Source files
------------

// File: rtl/neuron_stat_updater_pkg.sv
// Shared definitions for the neuron status sweep: status-memory field selects,
// sequencer states and the signed saturation limits used by the integrator.
package neuron_stat_updater_pkg;

   localparam logic [1:0] SEL_BIAS = 2'b00;
   localparam logic [1:0] SEL_POT  = 2'b01;
   localparam logic [1:0] SEL_TH   = 2'b10;
   localparam logic [1:0] SEL_HIST = 2'b11;

   typedef enum logic [3:0] {
      ST_IDLE = 4'd0,
      ST_RB   = 4'd1,
      ST_RP   = 4'd2,
      ST_RT   = 4'd3,
      ST_RH   = 4'd4,
      ST_CMP  = 4'd5,
      ST_WP   = 4'd6,
      ST_WH   = 4'd7,
      ST_DONE = 4'd8
   } state_t;

   // Largest (upper=1) or smallest (upper=0) two's complement value of a given width.
   function automatic logic signed [63:0] sat_limit(input int unsigned width, input logic upper);
      logic signed [63:0] lim_s;
      if (upper) begin
         lim_s = (64'sd1 <<< (width - 32'd1)) - 64'sd1;
      end else begin
         lim_s = -(64'sd1 <<< (width - 32'd1));
      end
      return lim_s;
   endfunction

endpackage

// File: rtl/nurn_integrate_cmp.sv
// Per-neuron datapath: saturating membrane integration, threshold compare and
// post-spike history update. Purely combinational; the sequencer registers results.
module nurn_integrate_cmp
   import neuron_stat_updater_pkg::*;
#(
   parameter int DSIZE              = 16,
   parameter int STDP_WIN_BIT_WIDTH = 8
) (
   input  logic [DSIZE-1:0]              bias,
   input  logic [DSIZE-1:0]              pot,
   input  logic [DSIZE-1:0]              th,
   input  logic [STDP_WIN_BIT_WIDTH-1:0] hist,
   output logic [DSIZE-1:0]              sum,
   output logic                          fire,
   output logic [STDP_WIN_BIT_WIDTH-1:0] next_hist
);

   localparam logic signed [63:0] MAX_WIDE = sat_limit(DSIZE, 1'b1);
   localparam logic signed [63:0] MIN_WIDE = sat_limit(DSIZE, 1'b0);
   localparam logic [DSIZE-1:0] SAT_MAX = MAX_WIDE[DSIZE-1:0];
   localparam logic [DSIZE-1:0] SAT_MIN = MIN_WIDE[DSIZE-1:0];
   localparam logic [STDP_WIN_BIT_WIDTH-1:0] HIST_MAX = '1;
   localparam logic [STDP_WIN_BIT_WIDTH-1:0] HIST_ONE = {{(STDP_WIN_BIT_WIDTH-1){1'b0}}, 1'b1};

   logic [DSIZE:0] wide_sum_s;

   // Integrate, clamp on overflow (top two bits of the wide sum disagree), compare, update history.
   always_comb begin
      wide_sum_s = {bias[DSIZE-1], bias} + {pot[DSIZE-1], pot};
      if (wide_sum_s[DSIZE] != wide_sum_s[DSIZE-1]) begin
         sum = wide_sum_s[DSIZE] ? SAT_MIN : SAT_MAX;
      end else begin
         sum = wide_sum_s[DSIZE-1:0];
      end
      fire = ($signed(sum) >= $signed(th));
      if (fire) begin
         next_hist = '0;
      end else if (hist == HIST_MAX) begin
         next_hist = hist;
      end else begin
         next_hist = hist + HIST_ONE;
      end
   end

endmodule

// File: rtl/neuron_stat_updater.sv
// Time-step sequencer: sweeps every neuron through read/integrate/compare/write-back
// against the status memory and emits one spike event per firing neuron.
module neuron_stat_updater
   import neuron_stat_updater_pkg::*;
#(
   parameter int NUM_NURNS          = 256,
   parameter int DSIZE              = 16,
   parameter int NURN_CNT_BIT_WIDTH = 8,
   parameter int STDP_WIN_BIT_WIDTH = 8
) (
   input  logic                          clk_i,
   input  logic                          rst_n_i,
   input  logic                          start_i,
   output logic                          busy_o,
   output logic                          done_o,
   output logic [NURN_CNT_BIT_WIDTH+1:0] Addr_StatRd_A_o,
   output logic                          rdEn_StatRd_A_o,
   input  logic [DSIZE-1:0]              data_StatRd_A_i,
   output logic [NURN_CNT_BIT_WIDTH+1:0] Addr_StatWr_B_o,
   output logic                          wrEn_StatWr_B_o,
   output logic [DSIZE-1:0]              data_StatWr_B_o,
   output logic                          spike_o,
   output logic [NURN_CNT_BIT_WIDTH-1:0] spikeNurnId_o
);

   localparam int NW = NURN_CNT_BIT_WIDTH;
   localparam int SW = STDP_WIN_BIT_WIDTH;
   localparam logic [NW-1:0] LAST_NURN = NW'(NUM_NURNS - 1);
   localparam logic [NW-1:0] NURN_ONE  = {{(NW-1){1'b0}}, 1'b1};

   state_t          state_r, next_state_s;
   logic [NW-1:0]   nurn_r, nurn_next_s;
   logic [DSIZE-1:0] bias_r, pot_r, th_r;
   logic [SW-1:0]   hist_r;

   logic [DSIZE-1:0] sum_s;
   logic             fire_s;
   logic [SW-1:0]    next_hist_s;

   logic             rd_en_s, wr_en_s, spike_s, busy_s, done_s;
   logic [NW+1:0]    rd_addr_s, wr_addr_s;
   logic [DSIZE-1:0] wr_data_s;
   logic [NW-1:0]    spike_id_s;

   nurn_integrate_cmp #(
      .DSIZE              (DSIZE),
      .STDP_WIN_BIT_WIDTH (SW)
   ) u_integrate_cmp (
      .bias      (bias_r),
      .pot       (pot_r),
      .th        (th_r),
      .hist      (hist_r),
      .sum       (sum_s),
      .fire      (fire_s),
      .next_hist (next_hist_s)
   );

   // Next state and next neuron index.
   always_comb begin
      next_state_s = state_r;
      nurn_next_s  = nurn_r;
      case (state_r)
         ST_IDLE: begin
            if (start_i) begin
               next_state_s = ST_RB;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_RB:  next_state_s = ST_RP;
         ST_RP:  next_state_s = ST_RT;
         ST_RT:  next_state_s = ST_RH;
         ST_RH:  next_state_s = ST_CMP;
         ST_CMP: next_state_s = ST_WP;
         ST_WP:  next_state_s = ST_WH;
         ST_WH: begin
            if (nurn_r == LAST_NURN) begin
               next_state_s = ST_DONE;
            end else begin
               next_state_s = ST_RB;
               nurn_next_s  = nurn_r + NURN_ONE;
            end
         end
         ST_DONE: begin
            next_state_s = ST_IDLE;
            nurn_next_s  = '0;
         end
         default: begin
            next_state_s = ST_IDLE;
            nurn_next_s  = '0;
         end
      endcase
   end

   // Outputs are decoded from the upcoming state so the registered ports line up with it.
   always_comb begin
      rd_en_s    = 1'b0;
      rd_addr_s  = '0;
      wr_en_s    = 1'b0;
      wr_addr_s  = '0;
      wr_data_s  = '0;
      spike_s    = 1'b0;
      spike_id_s = '0;
      busy_s     = 1'b0;
      done_s     = 1'b0;
      case (next_state_s)
         ST_RB: begin
            busy_s = 1'b1; rd_en_s = 1'b1; rd_addr_s = {nurn_next_s, SEL_BIAS};
         end
         ST_RP: begin
            busy_s = 1'b1; rd_en_s = 1'b1; rd_addr_s = {nurn_next_s, SEL_POT};
         end
         ST_RT: begin
            busy_s = 1'b1; rd_en_s = 1'b1; rd_addr_s = {nurn_next_s, SEL_TH};
         end
         ST_RH: begin
            busy_s = 1'b1; rd_en_s = 1'b1; rd_addr_s = {nurn_next_s, SEL_HIST};
         end
         ST_CMP: busy_s = 1'b1;
         ST_WP: begin
            busy_s    = 1'b1;
            wr_en_s   = 1'b1;
            wr_addr_s = {nurn_next_s, SEL_POT};
            if (fire_s) begin
               wr_data_s  = '0;
               spike_s    = 1'b1;
               spike_id_s = nurn_next_s;
            end else begin
               wr_data_s  = sum_s;
            end
         end
         ST_WH: begin
            busy_s    = 1'b1;
            wr_en_s   = 1'b1;
            wr_addr_s = {nurn_next_s, SEL_HIST};
            wr_data_s = DSIZE'(next_hist_s);
         end
         ST_DONE: done_s = 1'b1;
         default: busy_s = 1'b0;
      endcase
   end

   // Sequencer state, neuron index and operand capture (read data lags rdEn by one cycle).
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_r <= ST_IDLE;
         nurn_r  <= '0;
         bias_r  <= '0;
         pot_r   <= '0;
         th_r    <= '0;
         hist_r  <= '0;
      end else begin
         state_r <= next_state_s;
         nurn_r  <= nurn_next_s;
         case (state_r)
            ST_RP:   bias_r <= data_StatRd_A_i;
            ST_RT:   pot_r  <= data_StatRd_A_i;
            ST_RH:   th_r   <= data_StatRd_A_i;
            ST_CMP:  hist_r <= data_StatRd_A_i[SW-1:0];
            default: hist_r <= hist_r;
         endcase
      end
   end

   // Registered output ports.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         busy_o          <= 1'b0;
         done_o          <= 1'b0;
         Addr_StatRd_A_o <= '0;
         rdEn_StatRd_A_o <= 1'b0;
         Addr_StatWr_B_o <= '0;
         wrEn_StatWr_B_o <= 1'b0;
         data_StatWr_B_o <= '0;
         spike_o         <= 1'b0;
         spikeNurnId_o   <= '0;
      end else begin
         busy_o          <= busy_s;
         done_o          <= done_s;
         Addr_StatRd_A_o <= rd_addr_s;
         rdEn_StatRd_A_o <= rd_en_s;
         Addr_StatWr_B_o <= wr_addr_s;
         wrEn_StatWr_B_o <= wr_en_s;
         data_StatWr_B_o <= wr_data_s;
         spike_o         <= spike_s;
         spikeNurnId_o   <= spike_id_s;
      end
   end

endmodule

// File: tb/tb_neuron_stat_updater.sv
// Bench for neuron_stat_updater: status-memory model, table-driven sweeps checked
// through read/write/spike scoreboards, plus timing and mid-sweep reset sequences.
module tb_neuron_stat_updater;

   localparam int NN = 4;
   localparam int DS = 16;
   localparam int NW = 8;
   localparam int SW = 8;
   localparam int AW = NW + 2;

   typedef struct {
      logic [DS-1:0] bias;
      logic [DS-1:0] pot;
      logic [DS-1:0] th;
      logic [SW-1:0] hist;
      logic [DS-1:0] exp_pot;
      logic [SW-1:0] exp_hist;
      logic          exp_fire;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          busy, done, rd_en, wr_en, spike;
   logic [AW-1:0] rd_addr, wr_addr;
   logic [DS-1:0] rd_data, wr_data;
   logic [NW-1:0] spike_id;

   logic [DS-1:0] mem [0:(1<<AW)-1];
   logic          ld_en = 1'b0;
   logic [AW-1:0] ld_addr = '0;
   logic [DS-1:0] ld_data = '0;

   vec_t          tbl [8];
   logic [AW-1:0] rd_q [$];
   logic [AW+DS-1:0] wr_q [$];
   logic [NW-1:0] spk_q [$];
   int            total = 0;
   int            bad = 0;
   int            done_cnt = 0;

   neuron_stat_updater #(
      .NUM_NURNS(NN), .DSIZE(DS), .NURN_CNT_BIT_WIDTH(NW), .STDP_WIN_BIT_WIDTH(SW)
   ) dut (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .busy_o(busy), .done_o(done),
      .Addr_StatRd_A_o(rd_addr), .rdEn_StatRd_A_o(rd_en), .data_StatRd_A_i(rd_data),
      .Addr_StatWr_B_o(wr_addr), .wrEn_StatWr_B_o(wr_en), .data_StatWr_B_o(wr_data),
      .spike_o(spike), .spikeNurnId_o(spike_id)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ld_en) mem[ld_addr] <= ld_data;
      else if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (done) done_cnt++;
      if (rd_en || wr_en) check("en_exclusive", 32'(rd_en & wr_en), 32'd0);
      if (rd_en) begin
         if (rd_q.size() == 0) check("rd_unexpected", 32'(rd_addr), 32'hFFFF_FFFF);
         else check("rd_addr", 32'(rd_addr), 32'(rd_q.pop_front()));
      end else begin
         check("rd_idle_zero", 32'(rd_addr), 32'd0);
      end
      if (wr_en) begin
         if (wr_q.size() == 0) check("wr_unexpected", 32'({wr_addr, wr_data}), 32'hFFFF_FFFF);
         else check("wr_addr_data", 32'({wr_addr, wr_data}), 32'(wr_q.pop_front()));
      end else begin
         check("wr_idle_zero", 32'({wr_addr, wr_data}), 32'd0);
      end
      if (spike) begin
         check("spike_in_wp", 32'({wr_en, wr_addr[1:0]}), 32'h5);
         if (spk_q.size() == 0) check("spike_unexpected", 32'(spike_id), 32'hFFFF_FFFF);
         else check("spike_id", 32'(spike_id), 32'(spk_q.pop_front()));
      end else begin
         check("spike_id_idle", 32'(spike_id), 32'd0);
      end
   end

   task automatic mem_load(input logic [AW-1:0] a, input logic [DS-1:0] d);
      ld_addr = a; ld_data = d; ld_en = 1'b1;
      @(posedge clk); #1;
      ld_en = 1'b0;
   endtask

   task automatic load_set(input int base);
      for (int n = 0; n < NN; n++) begin
         mem_load({NW'(n), 2'b00}, tbl[base+n].bias);
         mem_load({NW'(n), 2'b01}, tbl[base+n].pot);
         mem_load({NW'(n), 2'b10}, tbl[base+n].th);
         mem_load({NW'(n), 2'b11}, DS'(tbl[base+n].hist));
      end
   endtask

   task automatic push_nurn(input int n, input vec_t v, input bit with_wr);
      logic [NW-1:0] id;
      id = NW'(n);
      rd_q.push_back({id, 2'b00}); rd_q.push_back({id, 2'b01});
      rd_q.push_back({id, 2'b10}); rd_q.push_back({id, 2'b11});
      if (with_wr) begin
         wr_q.push_back({id, 2'b01, v.exp_pot});
         wr_q.push_back({id, 2'b11, DS'(v.exp_hist)});
         if (v.exp_fire) spk_q.push_back(id);
      end
   endtask

   task automatic check_mem(input int n, input vec_t v, input bit updated);
      logic [NW-1:0] id;
      id = NW'(n);
      check("mem_bias", 32'(mem[{id, 2'b00}]), 32'(v.bias));
      check("mem_pot", 32'(mem[{id, 2'b01}]), updated ? 32'(v.exp_pot) : 32'(v.pot));
      check("mem_hist", 32'(mem[{id, 2'b11}]), updated ? 32'(v.exp_hist) : 32'(v.hist));
   endtask

   task automatic check_queues(input string tag);
      check({tag, "_rdq_empty"}, 32'(rd_q.size()), 32'd0);
      check({tag, "_wrq_empty"}, 32'(wr_q.size()), 32'd0);
      check({tag, "_spkq_empty"}, 32'(spk_q.size()), 32'd0);
   endtask

   task automatic outs_zero(input string tag);
      check({tag, "_ctrl"}, 32'({busy, done, rd_en, wr_en, spike}), 32'd0);
      check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
      check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
      check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
      check({tag, "_spike_id"}, 32'(spike_id), 32'd0);
   endtask

   task automatic run_sweep(input int base);
      bit got;
      load_set(base);
      for (int n = 0; n < NN; n++) push_nurn(n, tbl[base+n], 1'b1);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 7*NN + 8; c++) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            break;
         end
      end
      check("done_seen", 32'(got), 32'd1);
      @(posedge clk); #1;
      check_queues("sweep");
      for (int n = 0; n < NN; n++) check_mem(n, tbl[base+n], 1'b1);
   endtask

   initial begin
      int d0;
      //           bias      pot       th        hist    exp_pot   exp_hist fire
      tbl[0] = '{16'h0010, 16'h0070, 16'h0080, 8'h03, 16'h0000, 8'h00, 1'b1};
      tbl[1] = '{16'h0005, 16'h0010, 16'h0100, 8'h07, 16'h0015, 8'h08, 1'b0};
      tbl[2] = '{16'h0020, 16'h7FF0, 16'h7FFF, 8'h10, 16'h0000, 8'h00, 1'b1};
      tbl[3] = '{16'hFFF0, 16'h8005, 16'h0000, 8'h01, 16'h8000, 8'h02, 1'b0};
      tbl[4] = '{16'h0001, 16'h0000, 16'h0100, 8'hFF, 16'h0001, 8'hFF, 1'b0};
      tbl[5] = '{16'hFFFF, 16'h0000, 16'hFFFF, 8'h20, 16'h0000, 8'h00, 1'b1};
      tbl[6] = '{16'h8000, 16'h8000, 16'h8000, 8'h05, 16'h0000, 8'h00, 1'b1};
      tbl[7] = '{16'h0003, 16'hFFFE, 16'h0002, 8'hFE, 16'h0001, 8'hFF, 1'b0};

      repeat (2) @(posedge clk);
      @(negedge clk);
      outs_zero("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      run_sweep(0);
      run_sweep(4);

      // Cycle-exact handshake with an ignored second start in cycle 10.
      load_set(0);
      for (int n = 0; n < NN; n++) push_nurn(n, tbl[n], 1'b1);
      d0 = done_cnt;
      start = 1'b1;
      for (int k = 1; k <= 32; k++) begin
         @(posedge clk); #1;
         start = (k == 10);
         @(negedge clk);
         check($sformatf("busy_c%0d", k), 32'(busy), 32'((k >= 1) && (k <= 7*NN)));
         check($sformatf("done_c%0d", k), 32'(done), 32'(k == 7*NN + 1));
      end
      check("timing_done_count", 32'(done_cnt - d0), 32'd1);
      check_queues("timing");
      for (int n = 0; n < NN; n++) check_mem(n, tbl[n], 1'b1);

      // Reset during neuron 1's compare cycle.
      @(posedge clk); #1;
      load_set(0);
      push_nurn(0, tbl[0], 1'b1);
      push_nurn(1, tbl[1], 1'b0);
      d0 = done_cnt;
      start = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         start = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      outs_zero("midreset");
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("midreset_no_done", 32'(done_cnt - d0), 32'd0);
      check_queues("midreset");
      check_mem(0, tbl[0], 1'b1);
      check_mem(1, tbl[1], 1'b0);

      run_sweep(0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
